rv16_mul_arbiter: RTL and testbench
===================================

Name: rv16_mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 3-cycle 32-bit multiplier unit among NUM_REQ requesters (e.g. the integer pipe, address-generation unit and debug port).
- Accepts a valid/ready request per port, issues a single-cycle start to the multiplier, waits for its done pulse, and returns the result to the granted port.
- Sits between the requesters and the multiplier. All outputs are registered.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8).
- ID_W, 2, width of grant_id; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT_CYCLES, 16, watchdog limit in cycles; used only with RV16_MUL_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-port request valid; held until req_ready.
- req_op_a  in  32*NUM_REQ  packed operand A; port i is bits [32*i+31:32*i].
- req_op_b  in  32*NUM_REQ  packed operand B, same packing.
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse.
- rsp_result  out  32  result, valid while any rsp_valid bit is high.
- rsp_err  out  1  timeout flag qualified by rsp_valid; tied 0 when the feature is disabled.
- mul_start  out  1  start pulse to the multiplier.
- mul_op_a  out  32  operand A to the multiplier.
- mul_op_b  out  32  operand B to the multiplier.
- mul_result  in  32  result from the multiplier.
- mul_done  in  1  done pulse from the multiplier.
- mul_busy  in  1  busy level from the multiplier.
- arb_busy  out  1  high whenever state != IDLE.
- grant_id  out  ID_W  index of the currently or last granted port.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, grant_id=0, all outputs 0, mul_op_a/b=0. Reset applied mid-operation abandons the transaction with no response. The multiplier shares rst_n.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - Grant occurs if req_valid != 0 and mul_busy == 0.
  - Winner is the first set bit scanning upward from rr_ptr, wrapping at NUM_REQ-1 to 0.
  - At that edge: latch the winner's operands into mul_op_a/b, set grant_id, pulse req_ready[winner] and mul_start for exactly one cycle, rr_ptr <= (winner+1) mod NUM_REQ, go to ISSUE.
- ISSUE: deassert req_ready and mul_start, go to WAIT. req_valid is not sampled outside IDLE.
- WAIT:
  - On mul_done: rsp_result <= mul_result, rsp_valid[grant_id] pulses one cycle, rsp_err=0, go to IDLE.
  - mul_done seen in IDLE or ISSUE is ignored.
- Timing, with the grant edge E0:
  - req_ready and mul_start are high E0→E1.
  - The multiplier pulses mul_done E4→E5.
  - rsp_valid is high E5→E6.
  - Earliest next grant is at E6, giving one operation per 6 cycles.
- Requester contract: drop req_valid, or present a new request, in the cycle after req_ready is seen high. A valid left high is treated as a new request on a later IDLE.
- Single active requester: it is granted repeatedly regardless of rr_ptr.
- Arithmetic: the arbiter only passes values through; the result is the low 32 bits of a*b.
- mul_op_a/b hold their values until the next grant.

Optional Feature:
- Macro: RV16_MUL_ARB_TIMEOUT_EN.
- When defined:
  - A counter clears at the grant and increments each cycle in ISSUE/WAIT.
  - If it reaches TIMEOUT_CYCLES without mul_done: rsp_valid[grant_id] pulses with rsp_err=1 and rsp_result=0, go to IDLE.
  - A later stray mul_done is ignored.
  - If mul_done and expiry occur in the same cycle, done wins and rsp_err=0.
- When not defined: no counter is built, rsp_err is constant 0, and WAIT waits indefinitely.

Test Plan:
- Port 1 only, A=3, B=5 → req_ready=0b0010 at E0→E1, mul_start one cycle, rsp_valid=0b0010 at E5→E6, rsp_result=15, rsp_err=0.
- Port 0, A=0xFFFFFFFF, B=0xFFFFFFFF → rsp_result=0x00000001; then A=0x00010000, B=0x00010000 → rsp_result=0x00000000 (truncation).
- All 4 ports valid continuously with distinct operands → grant order 0,1,2,3,0; grants 6 cycles apart; each rsp_valid bit matches its own product.
- Port 2 granted, then port 3 asserts valid during WAIT → port 3 granted only at the first edge after the port 2 response; no overlap of mul_start with mul_busy=1.
- rst_n low during WAIT → all outputs 0 immediately, no rsp_valid; after release a port-0 request with A=7, B=6 returns 42.
- Feature on, TIMEOUT_CYCLES=16, stub multiplier that never pulses done → rsp_valid with rsp_err=1 and rsp_result=0 sixteen cycles after the grant edge, then state IDLE; a late stub mul_done is ignored.

Source files
------------

// File: rtl/rv16_mul_arbiter.sv
// Round-robin sharing of one 3-cycle multiplier among NUM_REQ ports; grant->response 5 cycles, 1 op per 6 cycles.
// Requests wait (req_ready low) while busy; RV16_MUL_ARB_TIMEOUT_EN adds a watchdog that returns rsp_err.
module rv16_mul_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [32*NUM_REQ-1:0]  req_op_a,
   input  logic [32*NUM_REQ-1:0]  req_op_b,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [31:0]            rsp_result,
   output logic                   rsp_err,
   output logic                   mul_start,
   output logic [31:0]            mul_op_a,
   output logic [31:0]            mul_op_b,
   input  logic [31:0]            mul_result,
   input  logic                   mul_done,
   input  logic                   mul_busy,
   output logic                   arb_busy,
   output logic [ID_W-1:0]        grant_id
);

   localparam int PW = ID_W + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr, rr_ptr_d;
   logic [ID_W-1:0]     winner;
   logic [PW-1:0]       sum, win_inc;
   logic [2*NUM_REQ-1:0] rot_full;
   logic [NUM_REQ-1:0]  rot;
   logic [31:0]         op_a_arr [NUM_REQ];
   logic [31:0]         op_b_arr [NUM_REQ];
   logic                grant_en;
   logic                tmo_expire;

   logic [NUM_REQ-1:0]  req_ready_d, rsp_valid_d;
   logic [31:0]         rsp_result_d, mul_op_a_d, mul_op_b_d;
   logic                rsp_err_d, mul_start_d;
   logic [ID_W-1:0]     grant_id_d;

   // Rotate so bit 0 is rr_ptr; the lowest set bit of the rotated vector wins.
   always_comb begin
      rot_full = {req_valid, req_valid} >> rr_ptr;
      rot      = rot_full[NUM_REQ-1:0];
      winner   = '0;
      sum      = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum = PW'(rr_ptr) + PW'(k);
            if (sum >= PW'(NUM_REQ))
               sum = sum - PW'(NUM_REQ);
            winner = sum[ID_W-1:0];
         end
      end
      win_inc = PW'(winner) + PW'(1);
      if (win_inc >= PW'(NUM_REQ))
         win_inc = '0;
   end

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) begin
         op_a_arr[i] = req_op_a[32*i +: 32];
         op_b_arr[i] = req_op_b[32*i +: 32];
      end
   end

   assign grant_en = (state_q == IDLE) && (|req_valid) && !mul_busy;

`ifdef RV16_MUL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         tmo_cnt <= '0;
      else if (grant_en)
         tmo_cnt <= '0;
      else if (state_q != IDLE)
         tmo_cnt <= tmo_cnt + 1'b1;
   end

   // Expires on the edge where the count would reach TIMEOUT_CYCLES.
   assign tmo_expire = (state_q == WAIT) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_expire = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grant_en) state_d = ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (mul_done || tmo_expire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_d  = '0;
      mul_start_d  = 1'b0;
      rsp_valid_d  = '0;
      rsp_err_d    = 1'b0;
      rsp_result_d = rsp_result;
      mul_op_a_d   = mul_op_a;
      mul_op_b_d   = mul_op_b;
      grant_id_d   = grant_id;
      rr_ptr_d     = rr_ptr;
      case (state_q)
         IDLE: begin
            if (grant_en) begin
               req_ready_d = NUM_REQ'(1) << winner;
               mul_start_d = 1'b1;
               mul_op_a_d  = op_a_arr[winner];
               mul_op_b_d  = op_b_arr[winner];
               grant_id_d  = winner;
               rr_ptr_d    = win_inc[ID_W-1:0];
            end
         end
         WAIT: begin
            // A real done beats a simultaneous expiry.
            if (mul_done) begin
               rsp_valid_d  = NUM_REQ'(1) << grant_id;
               rsp_result_d = mul_result;
            end else if (tmo_expire) begin
               rsp_valid_d  = NUM_REQ'(1) << grant_id;
               rsp_err_d    = 1'b1;
               rsp_result_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_ready  <= '0;
         rsp_valid  <= '0;
         rsp_result <= '0;
         rsp_err    <= 1'b0;
         mul_start  <= 1'b0;
         mul_op_a   <= '0;
         mul_op_b   <= '0;
         arb_busy   <= 1'b0;
         grant_id   <= '0;
         rr_ptr     <= '0;
      end else begin
         req_ready  <= req_ready_d;
         rsp_valid  <= rsp_valid_d;
         rsp_result <= rsp_result_d;
         rsp_err    <= rsp_err_d;
         mul_start  <= mul_start_d;
         mul_op_a   <= mul_op_a_d;
         mul_op_b   <= mul_op_b_d;
         arb_busy   <= (state_d != IDLE);
         grant_id   <= grant_id_d;
         rr_ptr     <= rr_ptr_d;
      end
   end

endmodule

// File: tb/tb_rv16_mul_arbiter.sv
// Bench for rv16_mul_arbiter: directed table, multi-cycle sequences and a randomized run against a reference model.
module tb_rv16_mul_arbiter;
   localparam int N = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [32*N-1:0] req_op_a, req_op_b;
   logic [N-1:0]    req_ready, rsp_valid;
   logic [31:0]     rsp_result, mul_op_a, mul_op_b, mul_result;
   logic            rsp_err, mul_start, arb_busy, mul_busy, m_done, force_done;
   logic [1:0]      grant_id;
   wire             mul_done = m_done | force_done;
   bit              hang = 1'b0;
   logic [1:0]      mcnt;
   logic [31:0]     ma, mb;
   int              n_vec = 0, n_err = 0, cyc = 0;

   rv16_mul_arbiter #(.NUM_REQ(N), .ID_W(2), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op_a(req_op_a), .req_op_b(req_op_b),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_err(rsp_err),
      .mul_start(mul_start), .mul_op_a(mul_op_a), .mul_op_b(mul_op_b), .mul_result(mul_result),
      .mul_done(mul_done), .mul_busy(mul_busy), .arb_busy(arb_busy), .grant_id(grant_id));

   always #5 clk = ~clk;

   // 3-cycle multiplier: start seen at E1, done high E4->E5, busy E1->E5.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcnt <= 2'd0; m_done <= 1'b0; mul_busy <= 1'b0; mul_result <= '0; ma <= '0; mb <= '0;
      end else begin
         m_done <= 1'b0;
         if (m_done) mul_busy <= 1'b0;
         if (mul_start && !hang) begin
            mcnt <= 2'd3; mul_busy <= 1'b1; ma <= mul_op_a; mb <= mul_op_b;
         end else if (mcnt != 2'd0) begin
            mcnt <= mcnt - 2'd1;
            if (mcnt == 2'd1) begin
               m_done <= 1'b1; mul_result <= ma * mb;
            end
         end
      end
   end

   typedef struct {
      int          port;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
   } vec_t;

   function automatic logic [N-1:0] oh(input int i);
      return N'(1) << i;
   endfunction

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 3))
         0:       return 32'hFFFF_FFFF;
         1:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      check("start_busy_overlap", 64'(mul_start & mul_busy), 64'd0);
   endtask

   task automatic drive_port(input int p, input logic v, input logic [31:0] a, input logic [31:0] b);
      req_valid[p]         = v;
      req_op_a[32*p +: 32] = a;
      req_op_b[32*p +: 32] = b;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_ops"}, {mul_op_a, mul_op_b}, 64'd0);
      check({tag, "_ctl"}, 64'({req_ready, rsp_valid, rsp_result, rsp_err, mul_start, arb_busy, grant_id}), 64'd0);
   endtask

   task automatic wait_grant(output int port);
      int waited;
      port = -1;
      waited = 0;
      while (port < 0 && waited < 40) begin
         step();
         waited++;
         for (int i = 0; i < N; i++) if (req_ready[i]) port = i;
      end
      if (port < 0) begin
         n_vec++; n_err++;
         $display("FAIL grant_timeout: no req_ready within 40 cycles (cycle %0d)", cyc);
      end
   endtask

   task automatic do_reset();
      req_valid = '0; req_op_a = '0; req_op_b = '0; force_done = 1'b0; hang = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic single_op(input int p, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int gp;
      drive_port(p, 1'b1, a, b);
      wait_grant(gp);
      check("so_req_ready", req_ready, oh(p));
      check("so_mul_start", mul_start, 1);
      check("so_grant_id", grant_id, p);
      check("so_mul_ops", {mul_op_a, mul_op_b}, {a, b});
      drive_port(p, 1'b0, 32'd0, 32'd0);
      step();
      check("so_pulse_end", {req_ready, mul_start}, 0);
      for (int k = 2; k <= 4; k++) begin
         step();
         check("so_early_rsp", rsp_valid, 0);
      end
      step();
      check("so_rsp_valid", rsp_valid, oh(p));
      check("so_rsp_result", rsp_result, exp);
      check("so_rsp_err", rsp_err, 0);
      step();
      check("so_rsp_pulse", rsp_valid, 0);
      check("so_idle", arb_busy, 0);
   endtask

   task automatic run_random(input int ncyc);
      logic [N-1:0] v, exp_ready, exp_rsp;
      logic [31:0]  a [N];
      logic [31:0]  b [N];
      logic [31:0]  rsp_val;
      int rr, free_at, rsp_at, rsp_port, w, p, c;
      v = '0; rr = 0; free_at = 0; rsp_at = -1; rsp_port = 0; rsp_val = '0; c = 0;
      for (int i = 0; i < N; i++) begin a[i] = '0; b[i] = '0; end
      for (int n = 0; n < ncyc; n++) begin
         step();
         c++;
         w = -1; exp_ready = '0; exp_rsp = '0;
         if (c >= free_at && v != 0) begin
            for (int k = 0; k < N; k++) begin
               p = (rr + k) % N;
               if (w < 0 && v[p]) w = p;
            end
            exp_ready = oh(w);
            rsp_at    = c + 5;
            rsp_port  = w;
            rsp_val   = a[w] * b[w];
            free_at   = c + 6;
            rr        = (w + 1) % N;
         end
         if (c == rsp_at) exp_rsp = oh(rsp_port);
         check("rnd_req_ready", req_ready, exp_ready);
         check("rnd_mul_start", mul_start, 64'(exp_ready != 0));
         check("rnd_rsp_valid", rsp_valid, exp_rsp);
         if (exp_rsp != 0) begin
            check("rnd_rsp_result", rsp_result, rsp_val);
            check("rnd_rsp_err", rsp_err, 0);
         end
         for (int i = 0; i < N; i++) begin
            if (i == w) begin
               v[i] = ($urandom_range(0, 1) == 1);
               if (v[i]) begin a[i] = rnd_op(); b[i] = rnd_op(); end
            end else if (!v[i] && $urandom_range(0, 3) == 0) begin
               v[i] = 1'b1; a[i] = rnd_op(); b[i] = rnd_op();
            end
            drive_port(i, v[i], a[i], b[i]);
         end
      end
      req_valid = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t        tbl [5];
      logic [31:0] qa [N];
      logic [31:0] qb [N];
      int gcount, rcount, last, last_t, gp, t0;

      tbl[0] = '{1, 32'd3,          32'd5,          32'd15};
      tbl[1] = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001};
      tbl[2] = '{0, 32'h0001_0000,  32'h0001_0000,  32'h0000_0000};
      tbl[3] = '{3, 32'h0000_1234,  32'h0000_0010,  32'h0001_2340};
      tbl[4] = '{2, 32'h8000_0000,  32'd2,          32'h0000_0000};

      req_valid = '0; req_op_a = '0; req_op_b = '0; force_done = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // All ports continuously valid: rotation 0,1,2,3,0 at 6-cycle spacing.
      for (int i = 0; i < N; i++) begin
         qa[i] = 32'h0001_0003 + 32'(i);
         qb[i] = 32'h0000_0101 * 32'(i + 2);
         drive_port(i, 1'b1, qa[i], qb[i]);
      end
      gcount = 0; rcount = 0; last = 0; last_t = 0;
      for (int n = 0; n < 50 && rcount < 5; n++) begin
         step();
         if (req_ready != 0) begin
            check("rr_order", req_ready, oh(gcount % N));
            if (gcount > 0) check("grant_spacing", cyc - last_t, 6);
            last_t = cyc;
            last = gcount % N;
            gcount++;
         end
         if (rsp_valid != 0) begin
            check("rr_rsp_port", rsp_valid, oh(last));
            check("rr_rsp_result", rsp_result, qa[last] * qb[last]);
            rcount++;
            if (rcount == 5) req_valid = '0;
         end
      end
      if (rcount < 5) begin
         n_vec++; n_err++;
         $display("FAIL rr_responses: saw %0d responses, expected 5", rcount);
      end
      req_valid = '0;
      step();

      for (int i = 0; i < 5; i++)
         single_op(tbl[i].port, tbl[i].a, tbl[i].b, tbl[i].exp);

      // Port 3 arrives while port 2 is in flight; it must wait for the response.
      drive_port(2, 1'b1, 32'd11, 32'd13);
      wait_grant(gp);
      check("p2_grant", gp, 2);
      drive_port(2, 1'b0, 32'd0, 32'd0);
      step();
      step();
      drive_port(3, 1'b1, 32'd17, 32'd19);
      for (int k = 3; k <= 6; k++) begin
         step();
         if (k < 6) check("p3_early_grant", req_ready, 0);
         if (k == 5) begin
            check("p2_rsp_valid", rsp_valid, oh(2));
            check("p2_rsp_result", rsp_result, 32'd143);
         end
      end
      check("p3_grant", req_ready, oh(3));
      check("p3_mul_op_a", mul_op_a, 32'd17);
      drive_port(3, 1'b0, 32'd0, 32'd0);
      repeat (5) step();
      check("p3_rsp_valid", rsp_valid, oh(3));
      check("p3_rsp_result", rsp_result, 32'd323);
      step();

      // Stray done while idle is ignored.
      force_done = 1'b1;
      step();
      force_done = 1'b0;
      check("stray_idle_rsp", rsp_valid, 0);
      check("stray_idle_busy", arb_busy, 0);

      // Reset during WAIT abandons the transaction.
      drive_port(1, 1'b1, 32'd9, 32'd9);
      wait_grant(gp);
      drive_port(1, 1'b0, 32'd0, 32'd0);
      step();
      step();
      #2 rst_n = 1'b0;
      #1;
      check_outputs_zero("mid_reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check("post_reset_no_rsp", rsp_valid, 0);
      end
      single_op(0, 32'd7, 32'd6, 32'd42);

      // Multiplier that never completes.
      do_reset();
      hang = 1'b1;
      drive_port(1, 1'b1, 32'd5, 32'd5);
      wait_grant(gp);
      drive_port(1, 1'b0, 32'd0, 32'd0);
      t0 = cyc;
`ifdef RV16_MUL_ARB_TIMEOUT_EN
      for (int k = 1; k <= 15; k++) begin
         step();
         check("tmo_early_rsp", rsp_valid, 0);
      end
      step();
      check("tmo_delay", cyc - t0, 16);
      check("tmo_rsp_valid", rsp_valid, oh(1));
      check("tmo_rsp_err", rsp_err, 1);
      check("tmo_rsp_result", rsp_result, 0);
      step();
      check("tmo_idle", arb_busy, 0);
      check("tmo_rsp_pulse", rsp_valid, 0);
      force_done = 1'b1;
      step();
      force_done = 1'b0;
      check("tmo_late_done", rsp_valid, 0);
      step();
      check("tmo_late_done2", rsp_valid, 0);
`else
      for (int k = 1; k <= 30; k++) begin
         step();
         check("hang_no_rsp", rsp_valid, 0);
         check("hang_busy", arb_busy, 1);
      end
      force_done = 1'b1;
      step();
      force_done = 1'b0;
      check("hang_release_rsp", rsp_valid, oh(1));
      check("hang_release_err", rsp_err, 0);
      step();
      check("hang_release_idle", arb_busy, 0);
`endif
      hang = 1'b0;

      do_reset();
      run_random(800);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
